adxl357_i2c_sequencer: RTL and testbench
========================================

Name: adxl357_i2c_sequencer

Overview:
Sequencer that owns the control inputs of the ADXL357 I2C master (dev/reg/data/ctrl word) and walks it through soft-reset and configuration. It then hands the bus to the master's hardware 11-byte data-ready mode and monitors each transfer for completion, NACK-stall and timeout. It sits between the host register file and the I2C master, on the 50 MHz system clock.

Parameters:
DEV_ADDR, 7'h1D, ADXL357 7-bit I2C address driven on o_dev_addr
CLK_RATE, 3'd6, value driven on ctrl[6:4] (6 = 390 kHz)
POR_WAIT_CYC, 32'd500000, i_clk cycles to wait after soft-reset write (10 ms)
TIMEOUT_CYC, 32'd200000, max i_clk cycles per transaction before error
SYNC_STAGES, 2, flops on i_i2c_status[1:0] before use

Ports:
i_clk  input  1  system clock, 50 MHz
i_rst_n  input  1  asynchronous active-low reset
i_init  input  1  one-cycle pulse: start init sequence (ignored unless IDLE/ERR)
i_run  input  1  level: 1 = stream samples after init, 0 = stop streaming
i_range  input  2  RANGE[1:0] (01 ±10g, 10 ±20g, 11 ±40g)
i_odr  input  4  FILTER ODR_LPF[3:0]
i_drdy  input  1  ADXL357 DRDY pin (already synchronised)
i_i2c_status  input  32  master status; [0] ready, [1] finish
o_i2c_ctrl  output  32  master ctrl: [0] enable, [1] rw_reg, [3:2] op_mode, [6:4] clk_rate, rest 0
o_dev_addr  output  7  device address
o_reg_addr  output  8  register address for CPU writes
o_w_data  output  8  write data for CPU writes
o_drdy  output  1  gated DRDY to master = i_drdy & (state==RUN)
o_busy  output  1  1 in any state except IDLE, RUN, ERR
o_init_done  output  1  1 in RUN
o_err  output  1  sticky error, cleared only by i_init or reset
o_err_code  output  2  01 timeout, 10 stall (ready not seen), 00 none
o_sample_pulse  output  1  one-cycle pulse per completed hardware read
o_sample_cnt  output  16  wrapping count of completed reads

Behaviour:
- Reset values: o_i2c_ctrl = {25'b0, CLK_RATE, 4'b0}, o_dev_addr = DEV_ADDR, o_reg_addr = 0, o_w_data = 0, all flags, counts and pulses 0, state IDLE.
- Status bits [1:0] are synchronised through SYNC_STAGES flops. fin_rise = rising edge of the synchronised finish. rdy_s = synchronised ready.
- Write table, index 0..3:
  - (0x2F, 0x52) soft reset
  - (0x2C, {6'b0, i_range})
  - (0x28, {4'b0, i_odr})
  - (0x2D, 0x00) measure mode
- i_range and i_odr are captured on i_init acceptance.
- States:
  - IDLE: on i_init, clear o_err/o_err_code, idx = 0, go to W_ISSUE.
  - W_ISSUE: drive reg/data from the table, op_mode = 00, rw_reg = 0, enable = 1. Hold enable until rdy_s = 0, then drop enable and go to W_WAIT.
  - W_WAIT: on fin_rise, go to idx==0 ? POR_WAIT : W_NEXT.
  - POR_WAIT: count POR_WAIT_CYC, then go to W_NEXT.
  - W_NEXT: idx == 3 ? go to RUN_ARM : idx++ and go to W_ISSUE. Before re-issue, W_ISSUE also requires rdy_s = 1 (the master has returned to IDLE).
  - RUN_ARM: wait rdy_s = 1, then drive op_mode = 10, rw_reg = 1, enable = 0, and go to RUN.
  - RUN: every fin_rise gives o_sample_pulse = 1 for one cycle and o_sample_cnt + 1 (0xFFFF wraps to 0). When i_run = 0, o_drdy is forced 0. A transfer already in flight completes and is counted, then the block goes to IDLE once rdy_s = 1 with op_mode restored to 00.
  - ERR: ctrl enable = 0, op_mode = 00, o_drdy = 0. Leave only on i_init, which acts as a full restart.
- Timeout counter: cleared on every state entry and on every fin_rise. Active in W_ISSUE, W_WAIT, RUN_ARM, and in RUN while a transfer is in flight (rdy_s = 0).
  - Expiry in W_ISSUE → ERR, code 10.
  - Expiry elsewhere → ERR, code 01.
- A NACK in the master (no finish, it returns to ready) shows as rdy_s = 1 in W_WAIT with no fin_rise for 8 consecutive cycles → ERR, code 10.
- fin_rise while i_init arrives in the same cycle: the fin_rise is processed, and i_init is ignored unless the state is IDLE or ERR.
- Asynchronous reset mid-transfer returns to IDLE immediately with all outputs at reset values. Master recovery is the master's own reset.

Test Plan:
- i_init with i_range = 01, i_odr = 4, and a bus model that ACKs all bytes → four writes in order (0x2F/0x52, 0x2C/0x01, 0x28/0x04, 0x2D/0x00), POR gap ≥ POR_WAIT_CYC after the first write, then o_init_done = 1 and o_i2c_ctrl[3:0] = 4'b1010.
- In RUN with i_run = 1, pulse i_drdy 5 times with completed reads → five o_sample_pulse and o_sample_cnt = 5. Preload o_sample_cnt to 0xFFFE and apply 3 reads → count reads 1.
- Device NACKs the address on the RANGE write → o_err = 1, o_err_code = 10, o_i2c_ctrl[0] = 0, and no further writes are issued.
- finish is never asserted (bus stuck low) during W_WAIT → ERR with code 01 exactly TIMEOUT_CYC cycles after state entry.
- i_run deasserted mid-read → that read completes and is counted, then IDLE. o_drdy stays 0 afterwards despite i_drdy toggling.
- Reset asserted during POR_WAIT → all outputs at reset values. A subsequent i_init restarts from the soft-reset write.

Source files
------------

// File: rtl/adxl357_i2c_sequencer.sv
// Drives the ADXL357 I2C master control word: soft-reset and configuration writes,
// then hands the bus to the master's hardware data-ready read mode and watches each transfer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for i_init
// S_W_ISSUE  | table entry on reg/data, enable held until master leaves ready
// S_W_WAIT   | write in flight, waiting for finish (NACK / timeout checked)
// S_POR_WAIT | settle time after the soft-reset write
// S_W_NEXT   | advance the write index or move on to arming
// S_RUN_ARM  | wait for master ready, then switch to hardware read mode
// S_RUN      | streaming; count completed reads, stop when i_run drops
// S_ERR      | sticky error, bus released, only i_init leaves
module adxl357_i2c_sequencer #(
    parameter logic [6:0]  DEV_ADDR     = 7'h1D,
    parameter logic [2:0]  CLK_RATE     = 3'd6,
    parameter logic [31:0] POR_WAIT_CYC = 32'd500000,
    parameter logic [31:0] TIMEOUT_CYC  = 32'd200000,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_init,
    input  logic        i_run,
    input  logic [1:0]  i_range,
    input  logic [3:0]  i_odr,
    input  logic        i_drdy,
    input  logic [31:0] i_i2c_status,
    output logic [31:0] o_i2c_ctrl,
    output logic [6:0]  o_dev_addr,
    output logic [7:0]  o_reg_addr,
    output logic [7:0]  o_w_data,
    output logic        o_drdy,
    output logic        o_busy,
    output logic        o_init_done,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic        o_sample_pulse,
    output logic [15:0] o_sample_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_W_ISSUE, S_W_WAIT, S_POR_WAIT, S_W_NEXT, S_RUN_ARM, S_RUN, S_ERR
    } state_t;

    localparam logic [31:0] TMO_LOAD = TIMEOUT_CYC - 32'd1;
    localparam logic [31:0] POR_LOAD = POR_WAIT_CYC - 32'd1;
    localparam logic [1:0]  ERR_TMO   = 2'b01;
    localparam logic [1:0]  ERR_STALL = 2'b10;

    state_t                 state_q;
    logic [1:0]             idx_q;
    logic [1:0]             range_q;
    logic [3:0]             odr_q;
    logic                   en_q, rw_q;
    logic [1:0]             op_mode_q;
    logic [7:0]             reg_addr_q, w_data_q;
    logic                   err_q;
    logic [1:0]             err_code_q;
    logic                   pulse_q;
    logic [15:0]            sample_cnt_q;
    logic [31:0]            tmr_q;
    logic [2:0]             nack_cnt_q;
    logic [SYNC_STAGES-1:0] rdy_sync_q, fin_sync_q;
    logic                   fin_prev_q;

    logic        rdy_s, fin_s, fin_rise;
    logic        tmr_act, tmr_expired;
    logic [1:0]  idx_d;
    logic [15:0] sample_cnt_d;
    logic        unused_status;

    assign unused_status = ^i_i2c_status[31:2];

    function automatic logic [15:0] wr_entry(input logic [1:0] idx,
                                             input logic [1:0] rng,
                                             input logic [3:0] odr);
        case (idx)
            2'd0:    return {8'h2F, 8'h52};
            2'd1:    return {8'h2C, 6'b0, rng};
            2'd2:    return {8'h28, 4'b0, odr};
            default: return {8'h2D, 8'h00};
        endcase
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdy_sync_q <= '0;
            fin_sync_q <= '0;
            fin_prev_q <= 1'b0;
        end else begin
            rdy_sync_q[0] <= i_i2c_status[0];
            fin_sync_q[0] <= i_i2c_status[1];
            for (int k = 1; k < SYNC_STAGES; k++) begin
                rdy_sync_q[k] <= rdy_sync_q[k-1];
                fin_sync_q[k] <= fin_sync_q[k-1];
            end
            fin_prev_q <= fin_s;
        end
    end

    assign rdy_s    = rdy_sync_q[SYNC_STAGES-1];
    assign fin_s    = fin_sync_q[SYNC_STAGES-1];
    assign fin_rise = fin_s & ~fin_prev_q;

    // Timeout only runs while we are actually waiting on the master.
    assign tmr_act = (state_q == S_W_ISSUE) || (state_q == S_W_WAIT) ||
                     (state_q == S_RUN_ARM) || ((state_q == S_RUN) && !rdy_s);
    assign tmr_expired  = tmr_act && (tmr_q == 32'd0);
    assign idx_d        = idx_q + 2'd1;
    assign sample_cnt_d = sample_cnt_q + 16'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            range_q      <= 2'd0;
            odr_q        <= 4'd0;
            en_q         <= 1'b0;
            rw_q         <= 1'b0;
            op_mode_q    <= 2'b00;
            reg_addr_q   <= 8'h00;
            w_data_q     <= 8'h00;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
            pulse_q      <= 1'b0;
            sample_cnt_q <= 16'h0000;
            tmr_q        <= 32'd0;
            nack_cnt_q   <= 3'd0;
        end else begin
            pulse_q <= 1'b0;
            if ((tmr_act || (state_q == S_POR_WAIT)) && (tmr_q != 32'd0))
                tmr_q <= tmr_q - 32'd1;

            unique case (state_q)
                S_IDLE, S_ERR: begin
                    if (i_init) begin
                        err_q      <= 1'b0;
                        err_code_q <= 2'b00;
                        range_q    <= i_range;
                        odr_q      <= i_odr;
                        idx_q      <= 2'd0;
                        {reg_addr_q, w_data_q} <= wr_entry(2'd0, i_range, i_odr);
                        en_q       <= 1'b0;
                        rw_q       <= 1'b0;
                        op_mode_q  <= 2'b00;
                        tmr_q      <= TMO_LOAD;
                        state_q    <= S_W_ISSUE;
                    end
                end

                // Enable only rises once the master is back in ready, so a
                // re-issue never lands on a transfer that is still closing.
                S_W_ISSUE: begin
                    if (tmr_expired) begin
                        en_q       <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_STALL;
                        state_q    <= S_ERR;
                    end else if (!en_q) begin
                        if (rdy_s)
                            en_q <= 1'b1;
                    end else if (!rdy_s) begin
                        en_q       <= 1'b0;
                        nack_cnt_q <= 3'd0;
                        tmr_q      <= TMO_LOAD;
                        state_q    <= S_W_WAIT;
                    end
                end

                S_W_WAIT: begin
                    if (fin_rise) begin
                        if (idx_q == 2'd0) begin
                            tmr_q   <= POR_LOAD;
                            state_q <= S_POR_WAIT;
                        end else begin
                            tmr_q   <= TMO_LOAD;
                            state_q <= S_W_NEXT;
                        end
                    end else if (tmr_expired) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TMO;
                        state_q    <= S_ERR;
                    end else if (rdy_s) begin
                        if (nack_cnt_q == 3'd7) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_STALL;
                            state_q    <= S_ERR;
                        end else begin
                            nack_cnt_q <= nack_cnt_q + 3'd1;
                        end
                    end else begin
                        nack_cnt_q <= 3'd0;
                    end
                end

                S_POR_WAIT: begin
                    if (tmr_q == 32'd0) begin
                        tmr_q   <= TMO_LOAD;
                        state_q <= S_W_NEXT;
                    end
                end

                S_W_NEXT: begin
                    tmr_q <= TMO_LOAD;
                    if (idx_q == 2'd3) begin
                        state_q <= S_RUN_ARM;
                    end else begin
                        idx_q   <= idx_d;
                        {reg_addr_q, w_data_q} <= wr_entry(idx_d, range_q, odr_q);
                        state_q <= S_W_ISSUE;
                    end
                end

                S_RUN_ARM: begin
                    if (tmr_expired) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TMO;
                        state_q    <= S_ERR;
                    end else if (rdy_s) begin
                        op_mode_q <= 2'b10;
                        rw_q      <= 1'b1;
                        en_q      <= 1'b0;
                        tmr_q     <= TMO_LOAD;
                        state_q   <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (fin_rise) begin
                        pulse_q      <= 1'b1;
                        sample_cnt_q <= sample_cnt_d;
                        tmr_q        <= TMO_LOAD;
                    end else if (tmr_expired) begin
                        op_mode_q  <= 2'b00;
                        rw_q       <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TMO;
                        state_q    <= S_ERR;
                    end else if (rdy_s) begin
                        tmr_q <= TMO_LOAD;
                        if (!i_run) begin
                            op_mode_q <= 2'b00;
                            rw_q      <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign o_i2c_ctrl     = {25'b0, CLK_RATE, op_mode_q, rw_q, en_q};
    assign o_dev_addr     = DEV_ADDR;
    assign o_reg_addr     = reg_addr_q;
    assign o_w_data       = w_data_q;
    assign o_drdy         = i_drdy & i_run & (state_q == S_RUN);
    assign o_busy         = (state_q != S_IDLE) && (state_q != S_RUN) && (state_q != S_ERR);
    assign o_init_done    = (state_q == S_RUN);
    assign o_err          = err_q;
    assign o_err_code     = err_code_q;
    assign o_sample_pulse = pulse_q;
    assign o_sample_cnt   = sample_cnt_q;

endmodule

// File: tb/tb_adxl357_i2c_sequencer.sv
// Bench for adxl357_i2c_sequencer: behavioural I2C master model, configuration
// vectors in a table, and hand-written sequences for streaming, NACK, timeout and reset.
`timescale 1ns/1ps
module tb_adxl357_i2c_sequencer;

    localparam int POR_CYC = 40;
    localparam int TMO_CYC = 60;
    localparam int WR_LEN  = 6;
    localparam int RD_LEN  = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_init = 1'b0, i_run = 1'b0, i_drdy = 1'b0;
    logic [1:0]  i_range = 2'b00;
    logic [3:0]  i_odr = 4'h0;
    logic [31:0] i_i2c_status;
    logic [31:0] o_i2c_ctrl;
    logic [6:0]  o_dev_addr;
    logic [7:0]  o_reg_addr, o_w_data;
    logic        o_drdy, o_busy, o_init_done, o_err, o_sample_pulse;
    logic [1:0]  o_err_code;
    logic [15:0] o_sample_cnt;

    always #10 clk = ~clk;

    adxl357_i2c_sequencer #(
        .DEV_ADDR(7'h1D), .CLK_RATE(3'd6),
        .POR_WAIT_CYC(32'd40), .TIMEOUT_CYC(32'd60), .SYNC_STAGES(2)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_init(i_init), .i_run(i_run),
        .i_range(i_range), .i_odr(i_odr), .i_drdy(i_drdy),
        .i_i2c_status(i_i2c_status), .o_i2c_ctrl(o_i2c_ctrl),
        .o_dev_addr(o_dev_addr), .o_reg_addr(o_reg_addr), .o_w_data(o_w_data),
        .o_drdy(o_drdy), .o_busy(o_busy), .o_init_done(o_init_done),
        .o_err(o_err), .o_err_code(o_err_code),
        .o_sample_pulse(o_sample_pulse), .o_sample_cnt(o_sample_cnt)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Master model: writes take WR_LEN cycles, hardware reads RD_LEN cycles.
    logic        m_rdy, m_fin, m_busy, m_nack, m_stuck, drdy_prev;
    int          m_cnt;
    logic        nack_en = 1'b0, stuck_en = 1'b0;
    logic [7:0]  nack_reg = 8'h00;
    logic [15:0] wr_log [64];
    int          wr_cyc [64];
    int          wr_n = 0;

    assign i_i2c_status = {30'b0, m_fin, m_rdy};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy <= 1'b1; m_fin <= 1'b0; m_busy <= 1'b0; m_nack <= 1'b0;
            m_stuck <= 1'b0; m_cnt <= 0; drdy_prev <= 1'b0;
        end else begin
            m_fin     <= 1'b0;
            drdy_prev <= o_drdy;
            if (!m_busy) begin
                if (o_i2c_ctrl[3:2] == 2'b00 && o_i2c_ctrl[0]) begin
                    m_busy  <= 1'b1; m_rdy <= 1'b0; m_cnt <= WR_LEN;
                    m_nack  <= nack_en && (o_reg_addr == nack_reg);
                    m_stuck <= stuck_en;
                    if (wr_n < 64) begin
                        wr_log[wr_n] <= {o_reg_addr, o_w_data};
                        wr_cyc[wr_n] <= cyc;
                    end
                    wr_n <= wr_n + 1;
                end else if (o_i2c_ctrl[3:2] == 2'b10 && o_drdy && !drdy_prev) begin
                    m_busy <= 1'b1; m_rdy <= 1'b0; m_cnt <= RD_LEN;
                    m_nack <= 1'b0; m_stuck <= 1'b0;
                end
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
            end else if (!m_stuck) begin
                m_busy <= 1'b0; m_rdy <= 1'b1; m_fin <= !m_nack;
            end
        end
    end

    int pulse_cnt = 0, drdy_hi = 0;
    always @(negedge clk) begin
        if (o_sample_pulse) pulse_cnt <= pulse_cnt + 1;
        if (o_drdy) drdy_hi <= drdy_hi + 1;
    end

    int n_cmp = 0, n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; i_init = 1'b0; i_drdy = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_init();
        @(negedge clk) i_init = 1'b1;
        @(negedge clk) i_init = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctrl"}, o_i2c_ctrl, 32'h0000_0060);
        check({tag, "_dev"}, {25'b0, o_dev_addr}, 32'h1D);
        check({tag, "_reg_data"}, {16'b0, o_reg_addr, o_w_data}, 32'h0);
        check({tag, "_flags"}, {26'b0, o_drdy, o_busy, o_init_done, o_err, o_err_code}, 32'h0);
        check({tag, "_pulse_cnt"}, {15'b0, o_sample_pulse, o_sample_cnt}, 32'h0);
    endtask

    task automatic drdy_read();
        @(negedge clk) i_drdy = 1'b1;
        @(negedge clk) i_drdy = 1'b0;
        repeat (RD_LEN + 12) @(negedge clk);
    endtask

    task automatic wait_init_done(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (o_init_done) begin ok = 1'b1; break; end
        end
        check({tag, "_init_done_reached"}, {31'b0, ok}, 32'h1);
    endtask

    task automatic wait_err(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (o_err) begin ok = 1'b1; break; end
        end
        check({tag, "_err_reached"}, {31'b0, ok}, 32'h1);
    endtask

    typedef struct {
        logic [1:0]  rng;
        logic [3:0]  odr;
        logic [15:0] exp_w1;
        logic [15:0] exp_w2;
    } vec_t;

    vec_t vecs [3];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, bp, bd, t0, t1;
        logic ok;

        vecs[0] = '{2'b01, 4'h4, 16'h2C01, 16'h2804};
        vecs[1] = '{2'b10, 4'hA, 16'h2C02, 16'h280A};
        vecs[2] = '{2'b11, 4'hF, 16'h2C03, 16'h280F};

        do_reset();
        check_reset_vals("reset");

        i_run = 1'b1;
        for (int v = 0; v < 3; v++) begin
            do_reset();
            base = wr_n;
            i_range = vecs[v].rng;
            i_odr   = vecs[v].odr;
            pulse_init();
            i_range = ~vecs[v].rng;
            i_odr   = ~vecs[v].odr;
            check($sformatf("v%0d_busy", v), {31'b0, o_busy}, 32'h1);
            wait_init_done($sformatf("v%0d", v));
            check($sformatf("v%0d_nwrites", v), wr_n - base, 32'd4);
            check($sformatf("v%0d_w0", v), {16'b0, wr_log[base]},   32'h2F52);
            check($sformatf("v%0d_w1", v), {16'b0, wr_log[base+1]}, {16'b0, vecs[v].exp_w1});
            check($sformatf("v%0d_w2", v), {16'b0, wr_log[base+2]}, {16'b0, vecs[v].exp_w2});
            check($sformatf("v%0d_w3", v), {16'b0, wr_log[base+3]}, 32'h2D00);
            check($sformatf("v%0d_por_gap", v),
                  {31'b0, (wr_cyc[base+1] - wr_cyc[base]) >= POR_CYC}, 32'h1);
            check($sformatf("v%0d_run_ctrl", v), o_i2c_ctrl, 32'h0000_006A);
            check($sformatf("v%0d_busy_run", v), {30'b0, o_busy, o_err}, 32'h0);
        end

        bp = pulse_cnt;
        for (int r = 0; r < 5; r++) drdy_read();
        check("stream_pulses", pulse_cnt - bp, 32'd5);
        check("stream_cnt", {16'b0, o_sample_cnt}, 32'd5);

        @(negedge clk) force dut.sample_cnt_q = 16'hFFFE;
        @(negedge clk) release dut.sample_cnt_q;
        @(negedge clk);
        check("wrap_preload", {16'b0, o_sample_cnt}, 32'hFFFE);
        bp = pulse_cnt;
        for (int r = 0; r < 3; r++) drdy_read();
        check("wrap_pulses", pulse_cnt - bp, 32'd3);
        check("wrap_cnt", {16'b0, o_sample_cnt}, 32'h0001);

        bp = pulse_cnt;
        @(negedge clk) i_drdy = 1'b1;
        @(negedge clk) i_drdy = 1'b0;
        repeat (5) @(negedge clk);
        i_run = 1'b0;
        repeat (30) @(negedge clk);
        check("stop_pulses", pulse_cnt - bp, 32'd1);
        check("stop_cnt", {16'b0, o_sample_cnt}, 32'h0002);
        check("stop_idle", {30'b0, o_init_done, o_busy}, 32'h0);
        check("stop_ctrl", o_i2c_ctrl, 32'h0000_0060);
        bd = drdy_hi;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk) i_drdy = 1'b1;
            @(negedge clk);
            @(negedge clk) i_drdy = 1'b0;
        end
        repeat (20) @(negedge clk);
        check("stop_drdy_gated", drdy_hi - bd, 32'd0);
        check("stop_no_more_pulses", pulse_cnt - bp, 32'd1);

        do_reset();
        nack_en = 1'b1; nack_reg = 8'h2C;
        base = wr_n;
        i_range = 2'b01; i_odr = 4'h4;
        pulse_init();
        wait_err("nack");
        check("nack_code", {30'b0, o_err_code}, 32'h2);
        check("nack_enable", {31'b0, o_i2c_ctrl[0]}, 32'h0);
        check("nack_flags", {30'b0, o_busy, o_init_done}, 32'h0);
        check("nack_w1", {16'b0, wr_log[base+1]}, 32'h2C01);
        repeat (100) @(negedge clk);
        check("nack_no_more_writes", wr_n - base, 32'd2);
        check("nack_err_sticky", {31'b0, o_err}, 32'h1);
        nack_en = 1'b0;

        do_reset();
        stuck_en = 1'b1;
        pulse_init();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_i2c_ctrl[0]) begin ok = 1'b1; break; end
        end
        check("tmo_enable_seen", {31'b0, ok}, 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!o_i2c_ctrl[0]) begin ok = 1'b1; break; end
        end
        check("tmo_wwait_entry", {31'b0, ok}, 32'h1);
        t0 = cyc;
        wait_err("tmo");
        t1 = cyc;
        check("tmo_cycles", t1 - t0, TMO_CYC);
        check("tmo_code", {30'b0, o_err_code}, 32'h1);
        stuck_en = 1'b0;

        do_reset();
        base = wr_n;
        i_range = 2'b11; i_odr = 4'h2;
        pulse_init();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr_n > base) begin ok = 1'b1; break; end
        end
        check("por_first_write", {31'b0, ok}, 32'h1);
        repeat (20) @(negedge clk);
        check("por_busy_before_reset", {31'b0, o_busy}, 32'h1);
        #5 rst_n = 1'b0;
        #1 check_reset_vals("por_reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("por_no_write_after_reset", wr_n - base, 32'd1);
        base = wr_n;
        i_range = 2'b10; i_odr = 4'h6;
        pulse_init();
        wait_init_done("restart");
        check("restart_nwrites", wr_n - base, 32'd4);
        check("restart_w0", {16'b0, wr_log[base]},   32'h2F52);
        check("restart_w1", {16'b0, wr_log[base+1]}, 32'h2C02);
        check("restart_w2", {16'b0, wr_log[base+2]}, 32'h2806);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
